// File: rtl/layer_serializer.sv
// layer_serializer
//   Captures one result vector of NB_POSITRON posits from the upstream
//   positron layer and replays it as a stream, one posit per accepted
//   word. The stream is framed with sow_o on the first word and eow_o on
//   the last word of each window.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   rts_i     : upstream result vector valid
//   rtr_o     : block can accept a result vector (only while IDLE)
//   posits_i  : result vector, positron k at [k*POSIT_WIDTH +: POSIT_WIDTH]
//   rts_o     : posit_o / sow_o / eow_o carry a valid stream word
//   rtr_i     : downstream accepts the current word
//   sow_o     : first word of a window
//   eow_o     : last word of a window
//   posit_o   : current stream word
module layer_serializer #(
  parameter int POSIT_WIDTH = 4,
  parameter int NB_POSITRON = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rts_i,
  output logic                               rtr_o,
  input  logic [NB_POSITRON*POSIT_WIDTH-1:0] posits_i,
  output logic                               rts_o,
  input  logic                               rtr_i,
  output logic                               sow_o,
  output logic                               eow_o,
  output logic [POSIT_WIDTH-1:0]             posit_o
);

  localparam int IDX_W = (NB_POSITRON > 1) ? $clog2(NB_POSITRON) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_POSITRON - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       index_reg;
  logic [POSIT_WIDTH-1:0] buffer_reg [NB_POSITRON];
  logic [POSIT_WIDTH-1:0] word_mux;
  logic                   capture;

  // Capture only happens from IDLE; while sending, upstream inputs are
  // ignored so a held rts_i/posits_i cannot disturb the buffered window.
  assign capture = (state_reg == IDLE) && rts_i;

  // Control FSM: index walks 0..NB_POSITRON-1 and stops at the last word,
  // handing back to IDLE on its acceptance (one bubble between windows).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      index_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rts_i) begin
            state_reg <= SEND;
            index_reg <= '0;
          end
        end
        SEND: begin
          if (rtr_i) begin
            if (index_reg == LAST_IDX) begin
              state_reg <= IDLE;
              index_reg <= '0;
            end else begin
              index_reg <= index_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          index_reg <= '0;
        end
      endcase
    end
  end

  // One register per positron slot, loaded in parallel on capture.
  generate
    for (genvar gi = 0; gi < NB_POSITRON; gi++) begin : g_buf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          buffer_reg[gi] <= '0;
        end else if (capture) begin
          buffer_reg[gi] <= posits_i[gi*POSIT_WIDTH +: POSIT_WIDTH];
        end
      end
    end
  endgenerate

  // Word select written as a compare-per-slot mux so the index width never
  // has to match the (possibly non power-of-two) buffer depth.
  always_comb begin
    word_mux = '0;
    for (int i = 0; i < NB_POSITRON; i++) begin
      if (index_reg == IDX_W'(i)) begin
        word_mux = buffer_reg[i];
      end
    end
  end

  // All outputs decode registered state only; nothing depends on rtr_i or
  // rts_i combinationally.
  assign rtr_o   = (state_reg == IDLE);
  assign rts_o   = (state_reg == SEND);
  assign posit_o = (state_reg == SEND) ? word_mux : '0;
  assign sow_o   = (state_reg == SEND) && (index_reg == '0);
  assign eow_o   = (state_reg == SEND) && (index_reg == LAST_IDX);

endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 Parameter POSIT_WIDTH, default 4, SHALL set the width of one posit word.
REQ-002 Parameter NB_POSITRON, default 16 (legal range 1..1024), SHALL set the number of posits captured per window and emitted per window.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 rts_i  input  1  SHALL mean the upstream positron layer has a valid result vector (AND of all positron rts_o).
REQ-006 rtr_o  output  1  SHALL mean the block can accept a result vector.
REQ-007 posits_i  input  NB_POSITRON*POSIT_WIDTH  SHALL carry the result vector; positron k occupies bits [k*POSIT_WIDTH +: POSIT_WIDTH].
REQ-008 rts_o  output  1  SHALL mean posit_o/sow_o/eow_o carry a valid stream word.
REQ-009 rtr_i  input  1  SHALL mean the downstream positron layer accepts the current word.
REQ-010 sow_o  output  1  SHALL flag the first word of a window.
REQ-011 eow_o  output  1  SHALL flag the last word of a window.
REQ-012 posit_o  output  POSIT_WIDTH  SHALL carry the current stream word.

Function
REQ-013 A transfer SHALL occur on any cycle where ready and valid are both high at the rising edge, on either side.
REQ-014 The FSM SHALL have two states: IDLE and SEND.
REQ-015 In IDLE: rtr_o=1, rts_o=0, and sow_o, eow_o and posit_o=0.
REQ-016 IDLE with rts_i=1 SHALL load all NB_POSITRON words into an internal buffer, clear the index counter to 0, and go to SEND.
REQ-017 In SEND: rtr_o=0 and rts_o=1.
- posit_o SHALL equal buffer[index].
- sow_o=(index==0) and eow_o=(index==NB_POSITRON-1).
REQ-018 SEND with rtr_i=1 and index<NB_POSITRON-1 SHALL increment index.
REQ-019 SEND with rtr_i=1 and index==NB_POSITRON-1 SHALL return to IDLE.
- The next capture can therefore happen at the earliest one cycle later (one bubble per window).
REQ-020 SEND with rtr_i=0 SHALL hold index, posit_o, sow_o and eow_o stable until the word is accepted.
REQ-021 Latency: the first word SHALL appear with rts_o=1 exactly one cycle after the capture edge.
REQ-022 A window SHALL take at least NB_POSITRON transfer cycles; rtr_o SHALL stay low for the whole window.
REQ-023 rts_i and posits_i SHALL be ignored while in SEND.
- Holding them (the upstream keeps them asserted) SHALL not corrupt the buffer.
REQ-024 With NB_POSITRON=1, sow_o and eow_o SHALL both be 1 on the single word.
REQ-025 The index counter SHALL be max(1, ceil(log2(NB_POSITRON))) bits wide and SHALL never wrap past NB_POSITRON-1.
REQ-026 Posit words SHALL pass bit-exact; NaR (1 followed by zeros) and zero SHALL get no special treatment.
REQ-027 All outputs SHALL be driven from registers or from the buffer mux, with no combinational path from rtr_i or rts_i to any output.

Reset
REQ-028 While rst_n=0, the FSM SHALL be in IDLE, index=0 and the buffer all zeros.
- Outputs SHALL be rtr_o=1, rts_o=0, sow_o=0, eow_o=0, posit_o=0.
REQ-029 Reset asserted mid-window SHALL abort the window immediately (asynchronously); no partial window SHALL resume after release.
REQ-030 The first capture after reset release SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-031 NB=4, W=4; rtr_i held 1; capture posits_i words k0..k3 = 0x1,0x2,0x3,0x8 ->
- posit_o SHALL be 1,2,3,8 on the 4 cycles after capture.
- sow_o SHALL be 1 on the first word only and eow_o 1 on the last word only.
- rtr_o SHALL be 0 for 4 cycles, then 1.
REQ-032 NB=4; rtr_i=0 for 3 cycles while on word index 1 (value 0x2) -> posit_o SHALL stay 0x2 and sow_o=0, eow_o=0 throughout; the remaining words follow unchanged after release.
REQ-033 NB=4; back-to-back vectors A then B with rts_i held 1 ->
- B SHALL be captured in the cycle after A's eow_o transfer.
- A's 4 words SHALL be followed by exactly one idle cycle (rts_o=0) before B's sow_o word.
REQ-034 NB=4; rst_n pulsed low during word index 2 ->
- rts_o=0 and posit_o=0 SHALL take effect immediately.
- After release, the next capture SHALL restart with sow_o on word 0.
REQ-035 NB=1; capture 0x8 (NaR) -> one word 0x8 with sow_o=1 and eow_o=1 SHALL appear; rtr_o returns to 1 on the next cycle.
